// File: rtl/instr_mem_loadable.sv
// Word-addressed instruction memory with a registered fetch port and a runtime loader write channel.
// Defining INSTR_MEM_FETCH_COUNT_EN adds a saturating fetch_count output.
module instr_mem_loadable #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  addr_error,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
`ifdef INSTR_MEM_FETCH_COUNT_EN
  output logic [15:0]           fetch_count,
`endif
  output logic                  busy
);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Contents are never reset; the all-zero (NOP) power-up image comes from device configuration.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0] instruction_q, instruction_d;
  logic                  addr_error_q, addr_error_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic                  fetch_acc;
  logic                  fetch_in_range;
  logic                  load_in_range;
  logic                  mem_we;
`ifdef INSTR_MEM_FETCH_COUNT_EN
  logic [15:0]           fetch_count_q, fetch_count_d;
`endif

  // Next-state, fetch response and loader bookkeeping
  always_comb begin
    state_d        = state_q;
    instruction_d  = instruction_q;
    load_count_d   = load_count_q;
    // A pending load blocks fetch acceptance in the same cycle, so the loader always wins.
    fetch_ready    = (state_q == RUN) && !load_valid;
    fetch_acc      = fetch_valid && fetch_ready;
    fetch_in_range = {1'b0, fetch_addr} < DEPTH_L;
    load_in_range  = {1'b0, load_addr} < DEPTH_L;
    mem_we         = load_valid && load_in_range;
    instr_valid_d  = fetch_acc;
    addr_error_d   = (fetch_acc && !fetch_in_range) || (load_valid && !load_in_range);

    if (fetch_acc) begin
      if (fetch_in_range) begin
        instruction_d = mem_q[fetch_addr];
      end else begin
        instruction_d = {DATA_WIDTH{1'b0}};
      end
    end else begin
      instruction_d = instruction_q;
    end

    case (state_q)
      RUN: begin
        if (load_valid) begin
          state_d      = LOAD;
          load_count_d = load_in_range ? {{ADDR_WIDTH{1'b0}}, 1'b1} : {(ADDR_WIDTH+1){1'b0}};
        end else begin
          state_d      = RUN;
        end
      end
      LOAD: begin
        if (mem_we && (load_count_q != COUNT_MAX)) begin
          load_count_d = load_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
          load_count_d = load_count_q;
        end
        if (load_done) begin
          state_d = RUN;
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      instr_valid_q <= 1'b0;
      instruction_q <= {DATA_WIDTH{1'b0}};
      addr_error_q  <= 1'b0;
      load_count_q  <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      addr_error_q  <= addr_error_d;
      load_count_q  <= load_count_d;
    end
  end

  // Loader write port into the storage array
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

`ifdef INSTR_MEM_FETCH_COUNT_EN
  // Fetch counter: restarts at each new load session, saturates at all-ones
  always_comb begin
    if ((state_q == RUN) && load_valid) begin
      fetch_count_d = 16'h0000;
    end else if (fetch_acc && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'h0001;
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  // Fetch counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q <= 16'h0000;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign addr_error  = addr_error_q;
  assign load_count  = load_count_q;
  assign busy        = (state_q == LOAD);

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable (DEPTH=24 so addresses 24..31 are out of range).
// A plain-array reference model predicts every response; random traffic is mixed with directed scenarios.
module tb_instr_mem_loadable;

  localparam int DW    = 32;
  localparam int DEPTH = 24;
  localparam int AW    = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          fetch_valid;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          instr_valid;
  logic [DW-1:0] instruction;
  logic          addr_error;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_done;
  logic [AW:0]   load_count;
  logic          busy;
`ifdef INSTR_MEM_FETCH_COUNT_EN
  logic [15:0]   fetch_count;
`endif

  instr_mem_loadable #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .addr_error  (addr_error),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_count  (load_count),
`ifdef INSTR_MEM_FETCH_COUNT_EN
    .fetch_count (fetch_count),
`endif
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory image, session flag, counters and last response
  logic [DW-1:0] m_mem [32];
  bit            m_load;
  int            m_count;
  int            m_fc;
  logic [DW-1:0] m_instr;
  bit            m_valid;
  bit            m_err;

  task automatic model_reset();
    m_load = 0; m_count = 0; m_fc = 0; m_instr = '0; m_valid = 0; m_err = 0;
  endtask

  task automatic drive(input bit fv, input int fa, input bit lv, input int la,
                       input logic [DW-1:0] ld, input bit dn);
    fetch_valid = fv; fetch_addr = AW'(fa);
    load_valid = lv; load_addr = AW'(la); load_data = ld; load_done = dn;
    #1;
  endtask

  // Applies the current inputs to the model, then advances one clock edge.
  task automatic tick();
    bit acc, ok;
    acc     = fetch_valid && !m_load && !load_valid;
    m_valid = acc;
    m_err   = 0;
    if (acc) begin
      if (fetch_addr < DEPTH) m_instr = m_mem[fetch_addr];
      else begin m_instr = '0; m_err = 1; end
      if (m_fc < 65535) m_fc++;
    end
    if (load_valid) begin
      ok = (load_addr < DEPTH);
      if (ok) m_mem[load_addr] = load_data; else m_err = 1;
      if (!m_load) begin m_count = ok ? 1 : 0; m_fc = 0; end
      else if (ok && m_count < 32) m_count++;
    end
    if (m_load) m_load = !load_done; else m_load = load_valid;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0);
    #10;
    checks += 6;
    if (fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", fetch_ready); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_ivalid got=%b exp=0", instr_valid); end
    if (instruction !== '0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction); end
    if (addr_error !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", addr_error); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (load_count !== '0) begin failures++; $display("FAIL reset_lcount got=%0d exp=0", load_count); end
`ifdef INSTR_MEM_FETCH_COUNT_EN
    checks++;
    if (fetch_count !== 16'h0) begin failures++; $display("FAIL reset_fcount got=%0d exp=0", fetch_count); end
`endif
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_load_fetch();
    drive(0, 0, 1, 0, 32'h11080002, 0); tick();
    drive(0, 0, 1, 1, 32'hAD880000, 0); tick();
    drive(0, 0, 1, 2, 32'h08000000, 0); tick();
    checks += 2;
    if (load_count !== 6'd3) begin failures++; $display("FAIL load_count3 got=%0d exp=3", load_count); end
    if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy); end
    drive(0, 0, 0, 0, '0, 1); tick();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%b exp=0", busy); end
    if (load_count !== 6'd3) begin failures++; $display("FAIL done_count got=%0d exp=3", load_count); end
    drive(1, 1, 0, 0, '0, 0);
    checks++;
    if (fetch_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready got=%b exp=1", fetch_ready); end
    tick();
    checks += 2;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL fetch1_valid got=%b exp=1", instr_valid); end
    if (instruction !== 32'hAD880000) begin failures++; $display("FAIL fetch1_data got=%h exp=ad880000", instruction); end
    drive(0, 0, 0, 0, '0, 0); tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_w [3];
    exp_w[0] = 32'h11080002; exp_w[1] = 32'hAD880000; exp_w[2] = 32'h08000000;
    for (int i = 0; i < 3; i++) begin
      drive(1, i, 0, 0, '0, 0); tick();
      checks += 2;
      if (instr_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, instr_valid); end
      if (instruction !== exp_w[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, instruction, exp_w[i]); end
    end
    drive(0, 0, 0, 0, '0, 0); tick();
    checks += 2;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", instr_valid); end
    if (instruction !== 32'h08000000) begin failures++; $display("FAIL b2b_hold got=%h exp=08000000", instruction); end
  endtask

  task automatic test_out_of_range();
    drive(1, 31, 0, 0, '0, 0); tick();
    checks += 3;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL oor_valid got=%b exp=1", instr_valid); end
    if (instruction !== '0) begin failures++; $display("FAIL oor_data got=%h exp=0", instruction); end
    if (addr_error !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", addr_error); end
    drive(0, 0, 0, 0, '0, 0); tick();
    checks++;
    if (addr_error !== 1'b0) begin failures++; $display("FAIL oor_err_pulse got=%b exp=0", addr_error); end
    drive(0, 0, 1, 5, 32'h55AA55AA, 0); tick();
    drive(0, 0, 1, 30, 32'hDEADBEEF, 0); tick();
    checks += 2;
    if (load_count !== 6'd1) begin failures++; $display("FAIL oor_lcount got=%0d exp=1", load_count); end
    if (addr_error !== 1'b1) begin failures++; $display("FAIL oor_lerr got=%b exp=1", addr_error); end
    drive(0, 0, 0, 0, '0, 1); tick();
    drive(1, 5, 0, 0, '0, 0); tick();
    checks++;
    if (instruction !== 32'h55AA55AA) begin failures++; $display("FAIL oor_prev_word got=%h exp=55aa55aa", instruction); end
    drive(0, 0, 0, 0, '0, 0); tick();
  endtask

  task automatic test_collision();
    drive(1, 1, 1, 1, 32'hCAFEF00D, 0);
    checks++;
    if (fetch_ready !== 1'b0) begin failures++; $display("FAIL col_ready got=%b exp=0", fetch_ready); end
    tick();
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL col_busy got=%b exp=1", busy); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL col_valid got=%b exp=0", instr_valid); end
    drive(1, 1, 0, 0, '0, 1); tick();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL col_done_busy got=%b exp=0", busy); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL col_load_fetch got=%b exp=0", instr_valid); end
    drive(1, 1, 0, 0, '0, 0); tick();
    checks += 2;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL col_retry_valid got=%b exp=1", instr_valid); end
    if (instruction !== 32'hCAFEF00D) begin failures++; $display("FAIL col_retry_data got=%h exp=cafef00d", instruction); end
    drive(0, 0, 0, 0, '0, 0); tick();
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 10 + i, 32'hA0000000 + DW'(i), 0); tick(); end
    drive(0, 0, 0, 0, '0, 1); tick();
    drive(0, 0, 1, 10, 32'hB0000010, 0); tick();
    drive(0, 0, 1, 11, 32'hB0000011, 0); tick();
    drive(0, 0, 0, 0, '0, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL rml_busy got=%b exp=0", busy); end
    if (load_count !== '0) begin failures++; $display("FAIL rml_lcount got=%0d exp=0", load_count); end
    if (fetch_ready !== 1'b1) begin failures++; $display("FAIL rml_ready got=%b exp=1", fetch_ready); end
    if (instruction !== '0) begin failures++; $display("FAIL rml_instr got=%h exp=0", instruction); end
`ifdef INSTR_MEM_FETCH_COUNT_EN
    checks++;
    if (fetch_count !== 16'h0) begin failures++; $display("FAIL rml_fcount got=%0d exp=0", fetch_count); end
`endif
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] expw;
      expw = (i < 2) ? (32'hB0000010 + DW'(i)) : (32'hA0000000 + DW'(i));
      drive(1, 10 + i, 0, 0, '0, 0); tick();
      checks += 2;
      if (instruction !== expw) begin failures++; $display("FAIL rml_word[%0d] got=%h exp=%h", i, instruction, expw); end
      if (instruction !== m_instr) begin failures++; $display("FAIL rml_model[%0d] got=%h exp=%h", i, instruction, m_instr); end
`ifdef INSTR_MEM_FETCH_COUNT_EN
      if (i == 2) begin
        checks++;
        if (fetch_count !== 16'd3) begin failures++; $display("FAIL rml_fcount3 got=%0d exp=3", fetch_count); end
      end
`endif
    end
    drive(0, 0, 0, 0, '0, 0); tick();
  endtask

  task automatic test_random();
    bit fv, lv, dn, exp_ready;
    for (int n = 0; n < 400; n++) begin
      fv = ($urandom_range(0, 3) != 0);
      lv = m_load ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      dn = m_load ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 5) == 0);
      drive(fv, $urandom_range(0, 31), lv, $urandom_range(0, 31), $urandom, dn);
      exp_ready = !m_load && !load_valid;
      checks++;
      if (fetch_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, fetch_ready, exp_ready); end
      tick();
      checks += 5;
      if (instr_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, instr_valid, m_valid); end
      if (instruction !== m_instr) begin failures++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", n, instruction, m_instr); end
      if (addr_error !== m_err) begin failures++; $display("FAIL rnd_err[%0d] got=%b exp=%b", n, addr_error, m_err); end
      if (busy !== m_load) begin failures++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", n, busy, m_load); end
      if (load_count !== 6'(m_count)) begin failures++; $display("FAIL rnd_lcount[%0d] got=%0d exp=%0d", n, load_count, m_count); end
`ifdef INSTR_MEM_FETCH_COUNT_EN
      checks++;
      if (fetch_count !== 16'(m_fc)) begin failures++; $display("FAIL rnd_fcount[%0d] got=%0d exp=%0d", n, fetch_count, m_fc); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    model_reset();
    test_reset();
    test_load_fetch();
    test_back_to_back();
    test_out_of_range();
    test_collision();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised, synchronous-read instruction memory that succeeds the fixed 8x32 combinational ROM.
- Word-addressed, single clock, with a loader write channel so a host or testbench can program it at runtime instead of relying on hard-coded initial contents.
- Sits between the PC/fetch stage and the decode stage.
- Fetch uses a valid/ready request with a registered one-cycle response.
- Out-of-range accesses are flagged rather than silently returning zero.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
DEPTH, 32, number of instruction words; must satisfy DEPTH <= 2**ADDR_WIDTH
ADDR_WIDTH, 5, word-address width of the fetch and load ports

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
fetch_valid  input  1  fetch request present
fetch_addr  input  ADDR_WIDTH  word address to fetch
fetch_ready  output  1  memory can accept a fetch this cycle
instr_valid  output  1  one-cycle pulse: instruction holds the response to the previous accepted fetch
instruction  output  DATA_WIDTH  fetched word; holds its value between responses
addr_error  output  1  one-cycle pulse: the last accepted fetch or load address was >= DEPTH
load_valid  input  1  loader write request
load_addr  input  ADDR_WIDTH  loader word address
load_data  input  DATA_WIDTH  loader write data
load_done  input  1  ends a load session
load_count  output  ADDR_WIDTH+1  number of words written in the current or last load session
busy  output  1  high while in LOAD state

Behaviour:
- Reset (reset_n=0, asynchronous): state=RUN; fetch_ready=1, instr_valid=0, instruction=0, addr_error=0, load_count=0, busy=0.
- The memory array is not cleared by reset. Its power-up contents are all zero (NOP).
- Reset asserted mid-load: state returns to RUN; words already written are kept.

States: RUN, LOAD.
- RUN -> LOAD: load_valid=1. The write for that cycle is performed and load_count is set to 1 (0 if out of range).
- LOAD -> RUN: load_done=1. If load_valid is also high that cycle, its write is performed first; the RUN transition takes effect next cycle.
- In LOAD: fetch_ready=0 and busy=1. Each load_valid cycle writes one word; load_count increments and saturates at 2**ADDR_WIDTH.
- load_done while in RUN is ignored.

Fetch:
- Accepted when fetch_valid && fetch_ready.
- Next cycle: instr_valid=1 and instruction=mem[fetch_addr].
- Back-to-back accepts every cycle give one response per cycle (full throughput).

Collisions and errors:
- Same-cycle load_valid and fetch_valid in RUN: the load wins and the state enters LOAD. fetch_ready for that cycle is combinationally 0, so the fetch is not accepted; the requester retries.
- Out-of-range fetch (addr >= DEPTH): next cycle instr_valid=1, instruction=0, addr_error=1.
- Out-of-range load: the write is dropped, addr_error=1 next cycle, and load_count does not increment.
- Write/read ordering: a word loaded in cycle N is visible to a fetch accepted in cycle N+1 or later.

Optional Feature:
Macro: INSTR_MEM_FETCH_COUNT_EN
- Defined: adds output fetch_count [15:0].
  - Resets to 0.
  - Increments on every accepted fetch, including out-of-range ones.
  - Saturates at 16'hFFFF.
  - Cleared synchronously on the RUN->LOAD transition.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> immediately fetch_ready=1, instr_valid=0, instruction=0, busy=0, load_count=0.
- Load then fetch:
  - Load addr0=32'h11080002, addr1=32'hAD880000, addr2=32'h08000000, then load_done. Expect load_count=3, then busy=0.
  - Fetch addr1 -> one cycle later instr_valid=1, instruction=32'hAD880000.
- Back-to-back: fetch 0,1,2 on consecutive cycles -> instruction 32'h11080002, 32'hAD880000, 32'h08000000 on three consecutive cycles, instr_valid continuously 1.
- Out of range: fetch addr 31 with DEPTH=24 -> instruction=0, addr_error=1 for one cycle. Load to addr 30 -> no write, load_count unchanged, addr_error=1.
- Collision: load_valid and fetch_valid in the same RUN cycle -> fetch_ready=0, the fetch is not accepted, busy=1 next cycle; after load_done the retried fetch returns the new data.
- Reset mid-load:
  - Write 2 of 4 words, then pulse reset_n -> state RUN, load_count=0.
  - The 2 written words are readable; the unwritten addresses return their prior contents.
  - With INSTR_MEM_FETCH_COUNT_EN defined: fetch_count=0 after reset, and 3 after three accepted fetches.
